// File: rtl/cape_sng_et.sv
// Multi-channel stochastic number generator: one shared or interleaved counter
// with runtime precision and optional bypass of trailing-zero counter bits.
module cape_sng_et #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int PW         = $clog2(WIDTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        en,
  input  logic                        corr_mode,
  input  logic                        et_en,
  input  logic [PW-1:0]               prec,
  input  logic [WIDTH*NUM_INPUTS-1:0] Bxs,
  output logic                        busy,
  output logic                        valid,
  output logic                        last,
  output logic                        done,
  output logic [NUM_INPUTS-1:0]       Xs
);

  localparam int CW = WIDTH*NUM_INPUTS;

  logic                                r_busy;
  logic                                r_done;
  logic                                r_corr;
  logic                                r_et;
  logic [PW-1:0]                       r_prec;
  logic [CW-1:0]                       r_bx;
  logic [CW-1:0]                       r_cnt;

  logic [NUM_INPUTS-1:0][WIDTH-1:0]    w_z;
  logic [NUM_INPUTS-1:0][WIDTH-1:0]    w_v;
  logic [NUM_INPUTS-1:0]               w_x;
  logic [CW-1:0]                       w_bp;
  logic [CW-1:0]                       w_sat;
  logic [CW-1:0]                       w_inc;
  logic                                w_all;

  function automatic logic [PW-1:0] sat_prec(input logic [PW-1:0] p);
    if (p == '0 || int'(p) > WIDTH)
      return PW'(WIDTH);
    else
      return p;
  endfunction

  function automatic logic [WIDTH-1:0] prec_mask(input logic [PW-1:0] p);
    logic [WIDTH-1:0] m;
    for (int j = 0; j < WIDTH; j++)
      m[j] = (j >= (WIDTH - int'(p)));
    return m;
  endfunction

  // Per-channel trailing-zero vectors and the resulting bypass mask
  always_comb begin
    logic v_run;
    w_z  = '0;
    w_bp = '1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      v_run = 1'b1;
      for (int j = 0; j < WIDTH; j++) begin
        v_run     = v_run & ~r_bx[i*WIDTH+j];
        w_z[i][j] = (j < (WIDTH - int'(r_prec))) || (r_et && v_run);
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (r_corr) begin
        w_bp[j] = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++)
          w_bp[j] = w_bp[j] & w_z[i][j];
      end else begin
        for (int i = 0; i < NUM_INPUTS; i++)
          w_bp[j*NUM_INPUTS+i] = w_z[i][j];
      end
    end
  end

  // Forcing bypassed bits to 1 lets the carry ripple straight through them
  assign w_sat = r_cnt | w_bp;
  assign w_all = &w_sat;
  assign w_inc = (w_sat + {{(CW-1){1'b0}}, 1'b1}) & ~w_bp;

  always_comb begin
    w_v = '0;
    w_x = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = 0; j < WIDTH; j++)
        w_v[i][j] = r_corr ? r_cnt[j] : r_cnt[j*NUM_INPUTS+i];
      w_x[i] = (w_v[i] < r_bx[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_corr <= 1'b0;
      r_et   <= 1'b0;
      r_prec <= '0;
      r_bx   <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= r_busy & en & w_all;
      if (!r_busy) begin
        if (start) begin
          r_busy <= 1'b1;
          r_corr <= corr_mode;
          r_et   <= et_en;
          r_prec <= sat_prec(prec);
          r_bx   <= Bxs & {NUM_INPUTS{prec_mask(sat_prec(prec))}};
          r_cnt  <= '0;
        end
      end else if (en) begin
        r_cnt <= w_inc;
        if (w_all)
          r_busy <= 1'b0;
      end
    end
  end

  assign busy  = r_busy;
  assign valid = r_busy & en;
  assign last  = valid & w_all;
  assign done  = r_done;
  assign Xs    = valid ? w_x : '0;

endmodule

// File: tb/tb_cape_sng_et.sv
// Directed bench: a 4-bit x 2 channel instance for correlated/ET/precision
// cases and a 2-bit x 2 channel instance for interleaved streams.
module tb_cape_sng_et;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, corr, et;
  logic       start_a, start_b;
  logic [2:0] prec_a;
  logic [1:0] prec_b;
  logic [7:0] bxs_a;
  logic [3:0] bxs_b;
  logic       busy_a, valid_a, last_a, done_a;
  logic       busy_b, valid_b, last_b, done_b;
  logic [1:0] xs_a, xs_b;

  cape_sng_et #(.WIDTH(4), .NUM_INPUTS(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .en(en), .corr_mode(corr),
    .et_en(et), .prec(prec_a), .Bxs(bxs_a), .busy(busy_a), .valid(valid_a),
    .last(last_a), .done(done_a), .Xs(xs_a)
  );

  cape_sng_et #(.WIDTH(2), .NUM_INPUTS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .en(en), .corr_mode(corr),
    .et_en(et), .prec(prec_b), .Bxs(bxs_b), .busy(busy_b), .valid(valid_b),
    .last(last_b), .done(done_b), .Xs(xs_b)
  );

  int          n_tot = 0;
  int          n_bad = 0;
  int          nvalid, ones0, ones1, viol, nz_idle, nlast, last_cyc, done_cyc, done_busy;
  logic [31:0] seq0, seq1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input bit sel, input bit c, input bit e, input int p,
                        input logic [7:0] bx);
    corr   = c;
    et     = e;
    prec_a = 3'(p);
    prec_b = 2'(p);
    bxs_a  = bx;
    bxs_b  = bx[3:0];
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Runs until done is seen; en follows pat, and a spurious start can be injected
  task automatic collect(input bit sel, input logic [3:0] pat, input int inject);
    bit         found;
    logic       v, l, d, b;
    logic [1:0] x;
    found = 1'b0;
    nvalid = 0; ones0 = 0; ones1 = 0; viol = 0; nz_idle = 0; nlast = 0;
    last_cyc = -1; done_cyc = -1; done_busy = -1; seq0 = '0; seq1 = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      en = pat[cyc%4];
      if (cyc == inject) begin
        start_a = 1'b1; bxs_a = 8'hFF; corr = 1'b0; et = 1'b1; prec_a = 3'd1;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      v = sel ? valid_b : valid_a;
      l = sel ? last_b  : last_a;
      d = sel ? done_b  : done_a;
      b = sel ? busy_b  : busy_a;
      x = sel ? xs_b    : xs_a;
      if (v) begin
        if (nvalid < 32) begin
          seq0[nvalid] = x[0];
          seq1[nvalid] = x[1];
        end
        ones0 += int'(x[0]);
        ones1 += int'(x[1]);
        if (x[1] && !x[0]) viol++;
        nvalid++;
      end else if (x != 2'b00) begin
        nz_idle++;
      end
      if (l) begin
        nlast++;
        last_cyc = cyc;
      end
      if (d) begin
        done_cyc  = cyc;
        done_busy = int'(b);
        found     = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
    en      = 1'b1;
    if (!found) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dseen;
    rst = 1'b1; en = 1'b0; corr = 1'b0; et = 1'b0; start_a = 1'b0; start_b = 1'b0;
    prec_a = '0; prec_b = '0; bxs_a = '0; bxs_b = '0;
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_xs", int'(xs_a), 0);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy_a), 0);

    // Full-precision correlated stream, Bx0=5 Bx1=3
    launch(0, 1, 0, 4, 8'h35);
    collect(0, 4'b1111, -1);
    chk("t1_len", nvalid, 16);
    chk("t1_ones0", ones0, 5);
    chk("t1_ones1", ones1, 3);
    chk("t1_corr_impl", viol, 0);
    chk("t1_nlast", nlast, 1);
    chk("t1_last_cyc", last_cyc, 15);
    chk("t1_done_cyc", done_cyc, 16);
    chk("t1_done_busy", done_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_done_pulse", int'(done_a), 0);

    // Early termination, Bx0=8 Bx1=4: counter steps 0,4,8,12
    launch(0, 1, 1, 4, 8'h48);
    collect(0, 4'b1111, -1);
    chk("t2_len", nvalid, 4);
    chk("t2_seq0", int'(seq0[3:0]), 4'b0011);
    chk("t2_seq1", int'(seq1[3:0]), 4'b0001);
    chk("t2_last_cyc", last_cyc, 3);

    // prec=2 masks Bx0=7 down to 4
    launch(0, 1, 0, 2, 8'h07);
    collect(0, 4'b1111, -1);
    chk("t3_len", nvalid, 4);
    chk("t3_ones0", ones0, 1);
    chk("t3_ones1", ones1, 0);

    // All operands zero with ET: single-bit stream
    launch(0, 1, 1, 4, 8'h00);
    collect(0, 4'b1111, -1);
    chk("t4_len", nvalid, 1);
    chk("t4_ones", ones0 + ones1, 0);
    chk("t4_nlast", nlast, 1);
    chk("t4_done_cyc", done_cyc, 1);

    // Out-of-range precision behaves as full width
    launch(0, 1, 0, 0, 8'h35);
    collect(0, 4'b1111, -1);
    chk("t5a_len", nvalid, 16);
    chk("t5a_ones0", ones0, 5);
    launch(0, 1, 0, 5, 8'h09);
    collect(0, 4'b1111, -1);
    chk("t5b_len", nvalid, 16);
    chk("t5b_ones0", ones0, 9);
    chk("t5b_ones1", ones1, 0);

    // Stalls 1,0,0,1 with a start pulsed mid-stream
    launch(0, 1, 0, 4, 8'h35);
    collect(0, 4'b1001, 5);
    chk("t6_len", nvalid, 16);
    chk("t6_seq0", int'(seq0[15:0]), 16'h001F);
    chk("t6_seq1", int'(seq1[15:0]), 16'h0007);
    chk("t6_nlast", nlast, 1);
    chk("t6_done_cyc", done_cyc, 32);
    chk("t6_idle_xs", nz_idle, 0);

    // Start during the done cycle: back-to-back stream
    launch(0, 1, 0, 4, 8'h35);
    collect(0, 4'b1111, -1);
    chk("t7_len", nvalid, 16);
    chk("t7_ones0", ones0, 5);
    chk("t7_ones1", ones1, 3);
    chk("t7_done_cyc", done_cyc, 16);

    // Reset mid-stream
    launch(0, 1, 0, 4, 8'h35);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t8_busy", int'(busy_a), 0);
    chk("t8_valid", int'(valid_a), 0);
    chk("t8_last", int'(last_a), 0);
    chk("t8_xs", int'(xs_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      dseen |= int'(done_a);
    end
    chk("t8_no_done", dseen, 0);
    launch(0, 1, 0, 4, 8'h35);
    collect(0, 4'b1111, -1);
    chk("t8_len", nvalid, 16);
    chk("t8_ones0", ones0, 5);
    chk("t8_ones1", ones1, 3);

    // Interleaved counter, WIDTH=2: Bx0=2 Bx1=1
    launch(1, 0, 0, 2, 8'h06);
    collect(1, 4'b1111, -1);
    chk("t9_len", nvalid, 16);
    chk("t9_ones0", ones0, 8);
    chk("t9_ones1", ones1, 4);
    chk("t9_seq0", int'(seq0[15:0]), 16'h0F0F);
    chk("t9_seq1", int'(seq1[15:0]), 16'h0033);

    // Interleaved with ET, Bx0=Bx1=2: bit 0 of both channels bypassed
    launch(1, 0, 1, 2, 8'h0A);
    collect(1, 4'b1111, -1);
    chk("t10_len", nvalid, 4);
    chk("t10_seq0", int'(seq0[3:0]), 4'b0101);
    chk("t10_seq1", int'(seq1[3:0]), 4'b0011);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/cape_sng_et.md
# cape_sng_et

Parametrised multi-channel stochastic number generator with runtime precision, correlated/uncorrelated mode select and optional early termination (ET). It converts NUM_INPUTS binary operands into unary bitstreams from a single bypass-capable counter. Operands are latched on `start`. The block emits one bit per channel per enabled cycle and signals completion with a `done` pulse. It feeds the SC arithmetic datapath in place of the fixed-mode generators and adds a start/stall/done handshake.

## Interface
- WIDTH, 8, operand width in bits.
- NUM_INPUTS, 4, number of channels.
- PW, $clog2(WIDTH+1), width of `prec`. Derived; do not override.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- start  in  1  launch request; accepted only when `busy`=0.
- en  in  1  stall control; when 0 during busy, counter holds and no bit is emitted.
- corr_mode  in  1  1 = shared WIDTH-bit counter (correlated streams); 0 = interleaved WIDTH*NUM_INPUTS-bit counter (uncorrelated streams). Sampled on start.
- et_en  in  1  1 = bypass trailing-zero counter bits. Sampled on start.
- prec  in  PW  active precision in bits, 1..WIDTH. 0 or >WIDTH is treated as WIDTH. Sampled on start.
- Bxs  in  WIDTH*NUM_INPUTS  operands; channel i occupies bits [i*WIDTH +: WIDTH]. Sampled on start.
- busy  out  1  stream in progress.
- valid  out  1  Xs holds a stream bit this cycle.
- last  out  1  final bit of stream (qualified by valid).
- done  out  1  one-cycle pulse after the final bit.
- Xs  out  NUM_INPUTS  stream bits, forced to 0 when valid=0.

## Operation
- IDLE→RUN on start: latch Bx_reg[i] = Bxs[i] with the low WIDTH-prec bits cleared; latch mode bits; clear counter C.
- Trailing-zero vector: z_i[j] = 1 iff j < WIDTH-prec, or (et_en and Bx_reg[i][j:0]==0).
- Bypass mask, corr_mode=1: C is WIDTH bits; bp[j] = AND over i of z_i[j].
- Bypass mask, corr_mode=0: C is WIDTH*NUM_INPUTS bits; bp[j*NUM_INPUTS+i] = z_i[j].
- Bypassed bits of C stay 0. The remaining A active bits increment as one contiguous binary counter, LSB-first, with carry skipping bypassed positions.
- Stream length L = 2^A. If all bits are bypassed (e.g. every Bx_reg = 0 with et_en), L = 1.
- Compare value for channel i: corr_mode=1 uses V_i = C; corr_mode=0 uses V_i[j] = C[j*NUM_INPUTS+i].
- Xs[i] = valid & (V_i < Bx_reg[i]), unsigned compare.
- last = valid & (all active bits of C are 1).
- RUN→IDLE on a cycle with en=1 and last=1. The counter then wraps to 0 and `done` pulses.
- start while busy is ignored; latched operands and modes do not change mid-stream.
- Per-channel ones count over the stream equals Bx_reg[i]*L/2^WIDTH exactly. This holds in every mode whenever bypassed bits are trailing zeros of every operand, which is guaranteed by construction.

## Timing
- Reset values: busy=0, valid=0, last=0, done=0, Xs=0, C=0, Bx_reg=0, modes=0.
- start sampled high at edge k: busy=1 from after edge k. First bit (C=0) is visible in the cycle after edge k when en=1.
- valid = busy & en, combinational from the busy register and en. One bit per valid cycle, so exactly L valid cycles per stream.
- Stall: en=0 holds C and shows valid=0. A stall on the last bit holds last until en returns.
- Final bit emitted in cycle m: busy=0 and done=1 in cycle m+1, and done=0 in cycle m+2.
- start in the same cycle done=1 is accepted, giving back-to-back streams with one idle cycle between them.
- rst asserted mid-stream: all outputs go to reset values immediately with no done pulse. The next start after rst release behaves normally.
- Counter width changes only at start; corr_mode does not affect latency rules.

## Test plan
- WIDTH=4, N=2, corr_mode=1, et_en=0, prec=4, Bx={5,3}, en=1: 16 valid cycles; ones counts 5 and 3; X1=1 implies X0=1 every cycle; done pulses 1 cycle after last.
- Same setup with et_en=1, Bx={8,4}: L=4; C steps 0,4,8,12; X0=1,1,0,0 and X1=1,0,0,0.
- WIDTH=2, N=2, corr_mode=0, et_en=0, Bx={2,1}: 16 valid cycles; ones counts 8 and 4; all 16 (V_0,V_1) pairs appear once.
- prec=2, WIDTH=4, corr, Bx0=7: masked to 4, L=4, ones=1. With Bx all zero and et_en=1: L=1, single valid bit Xs=0, last=1.
- en toggled 1,0,0,1 pattern mid-stream: valid-bit sequence identical to un-stalled run; start pulsed while busy has no effect.
- rst pulsed mid-stream: outputs zero same cycle, no done pulse; subsequent start yields full correct stream.
